// File: rtl/plic_pkg.sv
// Shared defaults, ID width helper and claim FSM encoding for the PLIC claim arbiter.
package plic_pkg;

    localparam int NSRC_DEFAULT   = 8;
    localparam int PRIO_W_DEFAULT = 3;
    localparam int NO_IRQ         = 0;

    // ID 0 is reserved for "none", so IDs span 0..n.
    function automatic int id_width(input int n);
        return $clog2(n + 1);
    endfunction

    typedef enum logic [1:0] {
        StIdle,
        StClaim,
        StResp
    } state_t;

endpackage

// File: rtl/plic_prio_select.sv
// Combinational max-priority search over eligible sources; ties resolve to the lowest ID.
module plic_prio_select
    import plic_pkg::*;
#(
    parameter int NSRC   = NSRC_DEFAULT,
    parameter int PRIO_W = PRIO_W_DEFAULT,
    localparam int ID_W  = id_width(NSRC)
) (
    input  logic [NSRC-1:0]        eligible,
    input  logic [NSRC*PRIO_W-1:0] prio,
    output logic [ID_W-1:0]        id,
    output logic                   valid
);

    logic [PRIO_W-1:0] best_prio;

    // Strict greater-than keeps the earlier (lower) ID on equal priority.
    always_comb begin
        best_prio = '0;
        id        = ID_W'(NO_IRQ);
        valid     = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (eligible[i] && (!valid || (prio[i*PRIO_W +: PRIO_W] > best_prio))) begin
                best_prio = prio[i*PRIO_W +: PRIO_W];
                id        = ID_W'(i + 1);
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/plic_claim_arbiter.sv
// Level-triggered interrupt gateway, registered arbitration and claim/complete sequencing
// for a single PLIC hart target.
module plic_claim_arbiter
    import plic_pkg::*;
#(
    parameter int NSRC   = NSRC_DEFAULT,
    parameter int PRIO_W = PRIO_W_DEFAULT,
    localparam int ID_W  = id_width(NSRC)
) (
    input  logic                   CLK100MHZ,
    input  logic                   CPU_RESETN,
    input  logic [NSRC-1:0]        src_irq,
    input  logic [NSRC-1:0]        src_en,
    input  logic [NSRC*PRIO_W-1:0] src_prio,
    input  logic [PRIO_W-1:0]      threshold,
    input  logic                   claim_req,
    output logic                   claim_ack,
    output logic [ID_W-1:0]        claim_id,
    input  logic                   complete_req,
    input  logic [ID_W-1:0]        complete_id,
    output logic                   eip,
    output logic                   busy
);

    state_t          state;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] in_flight;
    logic [NSRC-1:0] in_flight_cmp;
    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] cmp_mask;
    logic [NSRC-1:0] claim_mask;
    logic [ID_W-1:0] sel_id;
    logic [ID_W-1:0] best_id;
    logic            sel_valid;
    logic            best_valid;

    // Out-of-range complete IDs match no bit, so they fall out naturally.
    always_comb begin
        eligible   = '0;
        cmp_mask   = '0;
        claim_mask = '0;
        for (int i = 0; i < NSRC; i++) begin
            eligible[i]   = pending[i] & src_en[i] & (src_prio[i*PRIO_W +: PRIO_W] > threshold);
            cmp_mask[i]   = complete_req & in_flight[i] & (complete_id == ID_W'(i + 1));
            claim_mask[i] = (state == StClaim) & best_valid & (best_id == ID_W'(i + 1));
        end
    end

    // Gateway sees the post-complete in_flight so a held source re-pends the next cycle.
    assign in_flight_cmp = in_flight & ~cmp_mask;

    plic_prio_select #(
        .NSRC   (NSRC),
        .PRIO_W (PRIO_W)
    ) u_prio_select (
        .eligible (eligible),
        .prio     (src_prio),
        .id       (sel_id),
        .valid    (sel_valid)
    );

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            pending    <= '0;
            in_flight  <= '0;
            best_id    <= ID_W'(NO_IRQ);
            best_valid <= 1'b0;
        end else begin
            pending    <= (pending | (src_irq & ~in_flight_cmp)) & ~claim_mask;
            in_flight  <= in_flight_cmp | claim_mask;
            best_id    <= sel_id;
            best_valid <= sel_valid;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state     <= StIdle;
            claim_ack <= 1'b0;
            claim_id  <= ID_W'(NO_IRQ);
        end else begin
            claim_ack <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (claim_req) state <= StClaim;
                end
                StClaim: begin
                    claim_id  <= best_valid ? best_id : ID_W'(NO_IRQ);
                    claim_ack <= 1'b1;
                    state     <= StResp;
                end
                StResp: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign eip  = best_valid;
    assign busy = (state != StIdle);

endmodule

// File: tb/tb_plic_claim_arbiter.sv
// Randomized and directed bench for plic_claim_arbiter against a cycle-level behavioural model.
module tb_plic_claim_arbiter;

    localparam int NSRC   = 8;
    localparam int PRIO_W = 3;
    localparam int ID_W   = 4;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic [NSRC-1:0]        src_irq = '0;
    logic [NSRC-1:0]        src_en = '0;
    logic [NSRC*PRIO_W-1:0] src_prio = '0;
    logic [PRIO_W-1:0]      threshold = '0;
    logic                   claim_req = 1'b0;
    logic                   claim_ack;
    logic [ID_W-1:0]        claim_id;
    logic                   complete_req = 1'b0;
    logic [ID_W-1:0]        complete_id = '0;
    logic                   eip;
    logic                   busy;

    plic_claim_arbiter #(
        .NSRC   (NSRC),
        .PRIO_W (PRIO_W)
    ) dut (
        .CLK100MHZ    (clk),
        .CPU_RESETN   (rst_n),
        .src_irq      (src_irq),
        .src_en       (src_en),
        .src_prio     (src_prio),
        .threshold    (threshold),
        .claim_req    (claim_req),
        .claim_ack    (claim_ack),
        .claim_id     (claim_id),
        .complete_req (complete_req),
        .complete_id  (complete_id),
        .eip          (eip),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: sets of pending/claimed sources plus claim timestamps.
    bit m_pend[NSRC];
    bit m_infl[NSRC];
    bit inf_c[NSRC];
    int m_best_id = 0;
    bit m_best_v  = 0;
    int m_cyc     = 0;
    int claim_at  = -10;
    int ack_at    = -10;
    int exp_id    = 0;
    int nb_id, nb_p, cid;
    bit nb_v;

    function automatic int prio_of(input int i);
        return int'(src_prio[i*PRIO_W +: PRIO_W]);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NSRC; i++) begin
                m_pend[i] = 0;
                m_infl[i] = 0;
            end
            m_best_id = 0;
            m_best_v  = 0;
            claim_at  = -10;
            ack_at    = -10;
            exp_id    = 0;
        end else begin
            nb_v = 0;
            nb_id = 0;
            nb_p = 0;
            for (int i = 0; i < NSRC; i++) begin
                if (m_pend[i] && src_en[i] && prio_of(i) > int'(threshold) && prio_of(i) > nb_p)
                begin
                    nb_v  = 1;
                    nb_id = i + 1;
                    nb_p  = prio_of(i);
                end
            end
            for (int i = 0; i < NSRC; i++)
                inf_c[i] = m_infl[i] && !(complete_req && int'(complete_id) == i + 1);
            cid = 0;
            if (m_cyc == claim_at) begin
                cid    = m_best_v ? m_best_id : 0;
                exp_id = cid;
            end
            for (int i = 0; i < NSRC; i++) begin
                if (src_irq[i] && !inf_c[i]) m_pend[i] = 1;
                if (cid == i + 1) begin
                    m_pend[i] = 0;
                    inf_c[i]  = 1;
                end
                m_infl[i] = inf_c[i];
            end
            if (claim_req && m_cyc != claim_at && m_cyc != ack_at) begin
                claim_at = m_cyc + 1;
                ack_at   = m_cyc + 2;
            end
            m_best_id = nb_id;
            m_best_v  = nb_v;
        end
        m_cyc++;
    end

    always @(negedge clk) begin
        check("eip", int'(eip), int'(m_best_v));
        check("claim_ack", int'(claim_ack), int'(m_cyc == ack_at));
        check("busy", int'(busy), int'(m_cyc == claim_at || m_cyc == ack_at));
        check("claim_id", int'(claim_id), exp_id);
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) cyc();
    endtask

    task automatic set_prio(input int id, input int p);
        src_prio[(id-1)*PRIO_W +: PRIO_W] = PRIO_W'(p);
    endtask

    task automatic do_claim(output int id);
        claim_req = 1'b1;
        cyc();
        claim_req = 1'b0;
        cyc();
        check("claim_ack_pulse", int'(claim_ack), 1);
        id = int'(claim_id);
        wait_cycles(2);
    endtask

    task automatic do_complete(input int id);
        complete_req = 1'b1;
        complete_id  = ID_W'(id);
        cyc();
        complete_req = 1'b0;
        complete_id  = '0;
    endtask

    int got;

    initial begin
        #1 rst_n = 1'b0;
        wait_cycles(3);
        check("rst_eip", int'(eip), 0);
        check("rst_ack", int'(claim_ack), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_id", int'(claim_id), 0);
        rst_n = 1'b1;
        cyc();

        // Single source, ID3 prio 2.
        threshold = '0;
        src_en    = '1;
        set_prio(3, 2);
        src_irq = 8'h04;
        cyc();
        src_irq = '0;
        check("single_eip_t1", int'(eip), 0);
        cyc();
        check("single_eip_t2", int'(eip), 1);
        do_claim(got);
        check("single_claim_id", got, 3);
        check("single_eip_fall", int'(eip), 0);
        do_complete(3);
        wait_cycles(3);
        check("single_no_repend", int'(eip), 0);

        // Priority and tie-break: IDs 2,5,7 with prio 3,6,6.
        set_prio(2, 3);
        set_prio(5, 6);
        set_prio(7, 6);
        src_irq = 8'b0101_0010;
        cyc();
        src_irq = '0;
        wait_cycles(2);
        do_claim(got);
        check("tie_first", got, 5);
        do_claim(got);
        check("tie_second", got, 7);
        do_claim(got);
        check("tie_third", got, 2);
        do_claim(got);
        check("tie_none", got, 0);
        check("tie_eip_low", int'(eip), 0);
        do_complete(5);
        do_complete(7);
        do_complete(2);

        // Threshold masking and enable toggling on ID1 prio 4.
        set_prio(1, 4);
        threshold = 3'd4;
        src_irq = 8'h01;
        cyc();
        src_irq = '0;
        wait_cycles(3);
        check("thr_masked", int'(eip), 0);
        threshold = 3'd3;
        cyc();
        check("thr_unmasked", int'(eip), 1);
        src_en[0] = 1'b0;
        cyc();
        check("en_off", int'(eip), 0);
        src_en[0] = 1'b1;
        cyc();
        check("en_on", int'(eip), 1);

        // Level held during service.
        src_irq = 8'h01;
        do_claim(got);
        check("level_claim_id", got, 1);
        wait_cycles(3);
        check("level_in_service", int'(eip), 0);
        complete_req = 1'b1;
        complete_id  = 4'd1;
        cyc();
        complete_req = 1'b0;
        complete_id  = '0;
        check("level_repend_t1", int'(eip), 0);
        cyc();
        check("level_repend_t2", int'(eip), 1);
        src_irq = '0;
        do_claim(got);
        check("level_reclaim", got, 1);
        do_complete(1);
        wait_cycles(2);

        // Illegal completes and claim while busy.
        set_prio(2, 5);
        src_irq = 8'h02;
        cyc();
        src_irq = '0;
        wait_cycles(2);
        do_complete(0);
        do_complete(9);
        do_complete(2);
        cyc();
        check("illegal_eip_kept", int'(eip), 1);
        claim_req = 1'b1;
        cyc();
        cyc();
        check("busy_ack", int'(claim_ack), 1);
        check("busy_id", int'(claim_id), 2);
        cyc();
        claim_req = 1'b0;
        check("busy_drop_ack", int'(claim_ack), 0);
        cyc();
        check("busy_drop_idle", int'(busy), 0);
        do_complete(2);

        // Reset in the CLAIM cycle.
        src_irq = 8'h02;
        cyc();
        src_irq = '0;
        wait_cycles(2);
        claim_req = 1'b1;
        cyc();
        claim_req = 1'b0;
        check("mid_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ack", int'(claim_ack), 0);
        check("mid_rst_eip", int'(eip), 0);
        cyc();
        rst_n = 1'b1;
        wait_cycles(3);
        check("mid_after_ack", int'(claim_ack), 0);
        check("mid_after_eip", int'(eip), 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            src_irq = NSRC'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 49) == 0) src_en = NSRC'($urandom | $urandom);
            if ($urandom_range(0, 39) == 0) src_prio = (NSRC*PRIO_W)'($urandom);
            if ($urandom_range(0, 59) == 0)
                threshold = ($urandom_range(0, 7) == 0) ? 3'd7 : PRIO_W'($urandom_range(0, 3));
            claim_req    = ($urandom_range(0, 5) == 0);
            complete_req = ($urandom_range(0, 3) == 0);
            complete_id  = ID_W'(($urandom_range(0, 9) == 0) ? $urandom_range(9, 15)
                                                              : $urandom_range(0, 8));
            cyc();
        end
        claim_req    = 1'b0;
        complete_req = 1'b0;
        src_irq      = '0;
        wait_cycles(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/plic_claim_arbiter.md
Name: plic_claim_arbiter

Overview:
- Interrupt gateway and arbiter core for the PLIC target.
- Turns NSRC level-triggered sources into one external-interrupt line for a single hart target.
- Selects the highest-priority enabled pending source above the threshold and sequences claim/complete.
- Sits between the board-level source inputs (button-driven in the wrapper) and the display/hart logic.

Parameters:
- NSRC, 8, number of interrupt sources; IDs are 1..NSRC, ID 0 means "none".
- PRIO_W, 3, priority width; priority 0 means "never interrupts".
- ID_W, $clog2(NSRC+1), width of claim/complete IDs (derived localparam).

Ports:
- CLK100MHZ  in  1  system clock.
- CPU_RESETN  in  1  asynchronous active-low reset.
- src_irq  in  NSRC  level interrupt requests; bit i is source ID i+1.
- src_en  in  NSRC  per-source enable.
- src_prio  in  NSRC*PRIO_W  packed priorities; slice i is source ID i+1.
- threshold  in  PRIO_W  target threshold.
- claim_req  in  1  single-cycle claim strobe.
- claim_ack  out  1  claim response valid, 1 cycle.
- claim_id  out  ID_W  claimed ID; 0 if nothing eligible.
- complete_req  in  1  single-cycle completion strobe.
- complete_id  in  ID_W  ID being completed.
- eip  out  1  external interrupt pending to the target.
- busy  out  1  high while the FSM is not IDLE.

Behaviour:
- Reset (async assert, sync release): pending, in_flight, claim_ack, claim_id, eip, busy all 0; FSM enters IDLE.
- Gateway, per source i:
  - pending[i] sets on any cycle where src_irq[i]=1, pending[i]=0 and in_flight[i]=0.
  - pending[i] clears on the claim of ID i+1.
  - in_flight[i] sets on that claim and clears on a valid complete.
  - src_irq is ignored while in_flight[i]=1.
- Eligibility: pending & src_en & (prio > threshold). prio=0 is never eligible; threshold = 2^PRIO_W−1 masks all sources.
- Arbitration:
  - Combinational max-priority search; ties go to the lowest ID.
  - Result registered into best_id/best_valid (1-cycle latency).
  - eip = best_valid (registered).
  - Source asserted at cycle t → pending at t+1 → eip at t+2.
- FSM states:
  - IDLE: on claim_req → CLAIM.
  - CLAIM: latch best_id (0 if !best_valid); clear that pending bit; set its in_flight → RESP.
  - RESP: claim_ack=1 and claim_id valid for exactly this cycle → IDLE.
  - Claim latency: claim_req at t → claim_ack at t+2.
  - claim_req while not IDLE is dropped; no queueing.
  - claim_id holds its last value after claim_ack falls.
- Complete:
  - Processed in any FSM state, same cycle as complete_req.
  - Acts only if 1 ≤ complete_id ≤ NSRC and in_flight is set; otherwise silently ignored.
  - A source still asserted re-pends on the following cycle.
- Simultaneous events:
  - Complete and CLAIM on the same ID in one cycle: the claim wins (in_flight ends set). Software must not complete an unclaimed ID.
  - Gateway set and claim-clear on the same bit: the clear wins.
- Enable or priority change while pending: pending stays latched; only eligibility changes, visible on eip after 1 cycle.
- Reset mid-claim: FSM returns to IDLE; no ack is issued.

Decomposition:
- Package plic_pkg holds:
  - default NSRC and PRIO_W;
  - the ID_W function;
  - the FSM state enum (IDLE, CLAIM, RESP);
  - the NO_IRQ=0 constant.
- One sub-module, plic_prio_select: combinational max/lowest-ID tree over the eligible vector and priorities, outputting id and valid.
- Gateway and FSM stay in the top module.

Test Plan:
- Reset and single source:
  - Stimulus: threshold=0, src_en=all 1, prio ID3=2, pulse src_irq[2] 1 cycle at t.
  - Response: all outputs 0 during reset; eip=1 at t+2.
  - claim_req → claim_ack at +2 with claim_id=3; eip falls; complete_id=3 accepted; no re-pend because the source is low.
- Priority and tie-break:
  - Stimulus: IDs 2,5,7 pending with prio 3,6,6.
  - Response: successive claims return 5, 7, 2, then 0 with eip=0.
- Threshold and masking:
  - Stimulus: prio ID1=4, threshold=4.
  - Response: eip=0. Set threshold=3 → eip=1 one cycle later. Set src_en[0]=0 → eip=0; pending remains, and re-enabling restores eip.
- Level hold during service:
  - Stimulus: src_irq[0] held high; claim ID1.
  - Response: eip stays 0 until complete_id=1. eip re-asserts 2 cycles after the complete.
- Illegal and racing ops:
  - Stimulus: complete_id=0, complete_id=9, and complete of an unclaimed ID; claim_req while busy=1.
  - Response: state unchanged and no second ack.
- Reset mid-claim:
  - Stimulus: assert CPU_RESETN=0 in the CLAIM cycle.
  - Response: claim_ack never pulses; all pending/in_flight cleared; eip=0.
